// File: rtl/hamming_pkg.sv
// Shared Hamming code geometry: parity-bit count, code width and data-bit placement.
// Positions are 1-based with parity bits at powers of two; used by encoder and decoder.
package hamming_pkg;

  function automatic bit is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  // Smallest p with 2**p >= dw + p + 1.
  function automatic int calc_p(input int dw);
    int p;
    p = 0;
    for (int i = 30; i >= 1; i--) begin
      if ((1 << i) >= dw + i + 1) p = i;
    end
    return p;
  endfunction

  function automatic int calc_code_width(input int dw);
    return dw + calc_p(dw);
  endfunction

  // 1-based code position holding payload bit j.
  function automatic int data_pos(input int j);
    int n;
    int r;
    n = 0;
    r = 0;
    for (int pos = 1; pos <= 2 * j + 4; pos++) begin
      if (!is_pow2(pos)) begin
        if (n == j && r == 0) r = pos;
        n++;
      end
    end
    return r;
  endfunction

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_P          = calc_p(DEFAULT_DATA_WIDTH);
  localparam int DEFAULT_CODE_WIDTH = calc_code_width(DEFAULT_DATA_WIDTH);

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome: XOR of the 1-based positions of all set code bits.
// Zero latency; no handshake.
module hamming_syndrome
  import hamming_pkg::*;
#(
  parameter int CODE_WIDTH = DEFAULT_CODE_WIDTH,
  parameter int P          = DEFAULT_P
) (
  input  logic [CODE_WIDTH-1:0] code_i,
  output logic [P-1:0]          syn_o
);

  always_comb begin
    syn_o = '0;
    for (int ci = 1; ci <= CODE_WIDTH; ci++) begin
      if (code_i[ci-1]) syn_o = syn_o ^ P'(ci);
    end
  end

endmodule

// File: rtl/hamming_decoder_pipe.sv
// Two-stage SEC Hamming decoder (S1 syndrome, S2 correct/extract), 2-cycle latency, 1 word/clk.
// Backpressure: in_ready follows out_ready combinationally; stalled outputs hold stable.
module hamming_decoder_pipe
  import hamming_pkg::*;
#(
  parameter int  DATA_WIDTH = 8,
  parameter int  CNT_WIDTH  = 16,
  localparam int P          = calc_p(DATA_WIDTH),
  localparam int CODE_WIDTH = DATA_WIDTH + P
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CODE_WIDTH-1:0] code_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  err_corr,
  output logic                  err_uncorr,
  output logic [CNT_WIDTH-1:0]  corr_cnt,
  output logic [CNT_WIDTH-1:0]  uncorr_cnt,
  output logic [P-1:0]          last_syn,
  input  logic                  cnt_clr
);

  localparam logic [P-1:0] CW_SYN = P'(CODE_WIDTH);

  logic                  ready_q;
  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_raw_q, s1_raw_d, raw_w, fixed_w;
  logic [P-1:0]          s1_syn_q, s1_syn_d, syn_w;
  logic                  out_valid_q, out_valid_d;
  logic                  err_corr_q, err_corr_d, err_uncorr_q, err_uncorr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  corr_cnt_q, corr_cnt_d, uncorr_cnt_q, uncorr_cnt_d;
  logic [P-1:0]          last_syn_q, last_syn_d;
  logic                  s2_adv, s1_adv, in_xfer, syn_corr, syn_uncorr;

  hamming_syndrome #(.CODE_WIDTH(CODE_WIDTH), .P(P)) u_syn (
    .code_i (code_in),
    .syn_o  (syn_w)
  );

  // Parity bits are fully consumed by the syndrome, so S1 keeps only payload positions.
  // A syndrome pointing at a parity position therefore leaves the payload untouched.
  for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_data
    localparam int POS = data_pos(j);
    assign raw_w[j]   = code_in[POS-1];
    assign fixed_w[j] = s1_raw_q[j] ^ (syn_corr && (s1_syn_q == P'(POS)));
  end

  assign s2_adv     = !out_valid_q || out_ready;
  assign s1_adv     = s1_valid_q && s2_adv;
  assign in_ready   = ready_q && (!s1_valid_q || s2_adv);
  assign in_xfer    = in_valid && in_ready;
  assign syn_corr   = (s1_syn_q != '0) && (s1_syn_q <= CW_SYN);
  assign syn_uncorr = (s1_syn_q > CW_SYN);

  always_comb begin
    s1_valid_d   = in_ready ? in_valid : s1_valid_q;
    s1_raw_d     = in_xfer ? raw_w : s1_raw_q;
    s1_syn_d     = in_xfer ? syn_w : s1_syn_q;
    out_valid_d  = s2_adv ? s1_valid_q : out_valid_q;
    data_d       = data_q;
    err_corr_d   = err_corr_q;
    err_uncorr_d = err_uncorr_q;
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    last_syn_d   = last_syn_q;
    if (s1_adv) begin
      data_d       = fixed_w;
      err_corr_d   = syn_corr;
      err_uncorr_d = syn_uncorr;
    end
    // Statistics move only on the S1->S2 transfer; a coincident clear drops the event.
    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
      last_syn_d   = '0;
    end else if (s1_adv) begin
      if (syn_corr && (corr_cnt_q != '1))     corr_cnt_d   = corr_cnt_q + CNT_WIDTH'(1);
      if (syn_uncorr && (uncorr_cnt_q != '1)) uncorr_cnt_d = uncorr_cnt_q + CNT_WIDTH'(1);
      if (s1_syn_q != '0)                     last_syn_d   = s1_syn_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q      <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_raw_q     <= '0;
      s1_syn_q     <= '0;
      out_valid_q  <= 1'b0;
      data_q       <= '0;
      err_corr_q   <= 1'b0;
      err_uncorr_q <= 1'b0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
      last_syn_q   <= '0;
    end else begin
      ready_q      <= 1'b1;
      s1_valid_q   <= s1_valid_d;
      s1_raw_q     <= s1_raw_d;
      s1_syn_q     <= s1_syn_d;
      out_valid_q  <= out_valid_d;
      data_q       <= data_d;
      err_corr_q   <= err_corr_d;
      err_uncorr_q <= err_uncorr_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
      last_syn_q   <= last_syn_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign data_out   = data_q;
  assign err_corr   = err_corr_q;
  assign err_uncorr = err_uncorr_q;
  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;
  assign last_syn   = last_syn_q;

endmodule

// File: tb/tb_hamming_decoder_pipe.sv
// Bench for hamming_decoder_pipe: directed vector table, stall/saturation/reset sequences,
// and a randomized stream scored against an arithmetic decode model.
module tb_hamming_decoder_pipe;

  localparam int DW = 8;
  localparam int CW = 12;
  localparam int PW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, err_corr, err_uncorr, cnt_clr;
  logic [CW-1:0] code_in;
  logic [DW-1:0] data_out;
  logic [15:0]   corr_cnt, uncorr_cnt;
  logic [PW-1:0] last_syn;

  logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_err_corr, s_err_uncorr, s_cnt_clr;
  logic [CW-1:0] s_code_in;
  logic [DW-1:0] s_data_out;
  logic [1:0]    s_corr_cnt, s_uncorr_cnt;
  logic [PW-1:0] s_last_syn;

  hamming_decoder_pipe #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .code_in(code_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .err_corr(err_corr),
    .err_uncorr(err_uncorr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .last_syn(last_syn),
    .cnt_clr(cnt_clr)
  );

  hamming_decoder_pipe #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .code_in(s_code_in),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .data_out(s_data_out), .err_corr(s_err_corr),
    .err_uncorr(s_err_uncorr), .corr_cnt(s_corr_cnt), .uncorr_cnt(s_uncorr_cnt), .last_syn(s_last_syn),
    .cnt_clr(s_cnt_clr)
  );

  typedef struct packed {
    logic [PW-1:0] syn;
    logic [DW-1:0] data;
    logic          corr;
    logic          uncorr;
  } dec_t;

  typedef struct {
    string         name;
    logic [CW-1:0] code;
    logic [DW-1:0] data;
    logic          corr;
    logic          uncorr;
    logic [PW-1:0] syn;
  } vec_t;

  int            checks = 0;
  int            failures = 0;
  int            exp_corr = 0;
  int            exp_uncorr = 0;
  logic [PW-1:0] exp_last = '0;
  dec_t          exp_q[$];
  logic [CW-1:0] stim_q[$];
  vec_t          tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
    logic [CW-1:0] c;
    int j;
    c = '0;
    j = 0;
    for (int pos = 1; pos <= CW; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[j];
        j++;
      end
    end
    for (int k = 0; k < PW; k++) begin
      logic par;
      par = 1'b0;
      for (int pos = 1; pos <= CW; pos++) if (((pos >> k) & 1) == 1) par = par ^ c[pos-1];
      c[(1 << k) - 1] = par;
    end
    return c;
  endfunction

  function automatic dec_t ref_decode(input logic [CW-1:0] cw);
    dec_t r;
    logic [CW-1:0] c;
    int s;
    int j;
    c = cw;
    s = 0;
    for (int pos = 1; pos <= CW; pos++) if (c[pos-1]) s = s ^ pos;
    r.syn    = PW'(s);
    r.corr   = (s >= 1) && (s <= CW);
    r.uncorr = (s > CW);
    if (r.corr) c[s-1] = ~c[s-1];
    r.data = '0;
    j = 0;
    for (int pos = 1; pos <= CW; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        r.data[j] = c[pos-1];
        j++;
      end
    end
    return r;
  endfunction

  task automatic note_accept(input logic [CW-1:0] c);
    dec_t d;
    d = ref_decode(c);
    exp_q.push_back(d);
    if (d.corr) exp_corr++;
    if (d.uncorr) exp_uncorr++;
    if (d.syn != '0) exp_last = d.syn;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_corr_cnt"}, 32'(corr_cnt), 32'(exp_corr));
    chk({tag, "_uncorr_cnt"}, 32'(uncorr_cnt), 32'(exp_uncorr));
    chk({tag, "_last_syn"}, 32'(last_syn), 32'(exp_last));
  endtask

  // One isolated word with out_ready high; latency counted in rising edges from the accepting edge.
  task automatic check_single(input string name, input logic [CW-1:0] c, input logic [DW-1:0] d,
                              input logic ec, input logic eu);
    int n;
    int lat;
    dec_t unused_d;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    code_in   = c;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    @(posedge clk);
    #1;
    note_accept(c);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    unused_d = exp_q.pop_front();
    chk({name, "_latency"}, 32'(lat), 32'd2);
    chk({name, "_data"}, 32'(data_out), 32'(d));
    chk({name, "_flags"}, 32'({err_corr, err_uncorr}), 32'({ec, eu}));
    check_counters(name);
    tick();
  endtask

  // mode 0: fixed 3-cycle out_ready stall mid-stream; mode 1: random valid gaps and backpressure.
  task automatic run_stream(input string name, input int mode);
    int   n, sent, got, cyc;
    logic saw_block, prev_stall;
    logic [10:0] prev_word;
    dec_t e;
    n = stim_q.size();
    sent = 0;
    got = 0;
    saw_block = 1'b0;
    prev_stall = 1'b0;
    prev_word = '0;
    for (cyc = 0; cyc < 3000 && got < n; cyc++) begin
      out_ready = (mode == 0) ? !(cyc >= 2 && cyc < 5) : ($urandom_range(0, 9) < 7);
      in_valid  = (sent < n) && (mode == 0 || $urandom_range(0, 3) != 0);
      code_in   = (sent < n) ? stim_q[sent] : '0;
      #1;
      if (!in_ready) saw_block = 1'b1;
      if (prev_stall) chk({name, "_hold"}, 32'({out_valid, err_corr, err_uncorr, data_out}), 32'(prev_word));
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_valid, err_corr, err_uncorr, data_out};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk({name, "_spurious_out"}, 32'(got), 32'(n));
        end else begin
          e = exp_q.pop_front();
          chk({name, "_data"}, 32'(data_out), 32'(e.data));
          chk({name, "_flags"}, 32'({err_corr, err_uncorr}), 32'({e.corr, e.uncorr}));
        end
        got++;
      end
      if (in_valid && in_ready) begin
        note_accept(stim_q[sent]);
        sent++;
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk({name, "_words_out"}, 32'(got), 32'(n));
    if (mode == 0) chk({name, "_in_ready_dropped"}, 32'(saw_block), 32'd1);
    check_counters(name);
    exp_q.delete();
    stim_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [CW-1:0] w;
    tbl[0] = '{"clean",     12'hA27, 8'hA5, 1'b0, 1'b0, 4'd0};
    tbl[1] = '{"err_pos6",  12'hA07, 8'hA5, 1'b1, 1'b0, 4'd6};
    tbl[2] = '{"syn13",     12'h226, 8'h25, 1'b0, 1'b1, 4'd13};
    tbl[3] = '{"err_pos1",  12'hA26, 8'hA5, 1'b1, 1'b0, 4'd1};
    tbl[4] = '{"err_pos12", 12'h227, 8'hA5, 1'b1, 1'b0, 4'd12};
    tbl[5] = '{"err_pos2",  12'hA25, 8'hA5, 1'b1, 1'b0, 4'd2};
    tbl[6] = '{"err_pos11", 12'hE27, 8'hA5, 1'b1, 1'b0, 4'd11};
    tbl[7] = '{"syn14",     12'h225, 8'h25, 1'b0, 1'b1, 4'd14};
    tbl[8] = '{"syn15",     12'h223, 8'h24, 1'b0, 1'b1, 4'd15};

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; code_in = '0; cnt_clr = 1'b0;
    s_in_valid = 1'b0; s_out_ready = 1'b1; s_code_in = '0; s_cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_flags", 32'({err_corr, err_uncorr}), 32'd0);
    check_counters("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready_before_edge", 32'(in_ready), 32'd0);
    tick();
    chk("release_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 9; i++) begin
      check_single(tbl[i].name, tbl[i].code, tbl[i].data, tbl[i].corr, tbl[i].uncorr);
      if (tbl[i].syn != '0) chk({tbl[i].name, "_tbl_syn"}, 32'(last_syn), 32'(tbl[i].syn));
    end

    for (int i = 0; i < 4; i++) stim_q.push_back(encode(8'(8'h11 * (i + 1))) ^ (12'h1 << (i * 3 + 1)));
    run_stream("backpressure", 0);

    for (int i = 0; i < 80; i++) begin
      w = encode(8'($urandom));
      case ($urandom_range(0, 2))
        1: w[$urandom_range(0, CW - 1)] ^= 1'b1;
        2: begin
          int a, b;
          a = $urandom_range(0, CW - 1);
          b = (a + $urandom_range(1, CW - 1)) % CW;
          w[a] ^= 1'b1;
          w[b] ^= 1'b1;
        end
        default: ;
      endcase
      stim_q.push_back(w);
    end
    run_stream("random", 1);

    for (int i = 0; i < 5; i++) begin
      s_in_valid = 1'b1;
      s_code_in  = encode(8'(i * 37 + 3)) ^ (12'h1 << i);
      tick();
    end
    s_in_valid = 1'b0;
    repeat (3) tick();
    chk("sat_corr_cnt", 32'(s_corr_cnt), 32'd3);
    chk("sat_uncorr_cnt", 32'(s_uncorr_cnt), 32'd0);
    chk("sat_last_syn", 32'(s_last_syn), 32'd5);
    s_in_valid = 1'b1;
    s_code_in  = encode(8'h77) ^ 12'h040;
    tick();
    s_in_valid = 1'b0;
    s_cnt_clr  = 1'b1;
    tick();
    s_cnt_clr = 1'b0;
    chk("clr_word_out_valid", 32'(s_out_valid), 32'd1);
    chk("clr_word_err_corr", 32'(s_err_corr), 32'd1);
    chk("clr_word_data", 32'(s_data_out), 32'h77);
    chk("clr_corr_cnt", 32'(s_corr_cnt), 32'd0);
    chk("clr_last_syn", 32'(s_last_syn), 32'd0);
    tick();
    chk("clr_corr_cnt_after", 32'(s_corr_cnt), 32'd0);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    code_in   = encode(8'h3C) ^ 12'h004;
    repeat (3) tick();
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_data_out", 32'(data_out), 32'd0);
    chk("midrst_corr_cnt", 32'(corr_cnt), 32'd0);
    chk("midrst_uncorr_cnt", 32'(uncorr_cnt), 32'd0);
    chk("midrst_last_syn", 32'(last_syn), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    exp_corr = 0;
    exp_uncorr = 0;
    exp_last = '0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("restart_in_ready", 32'(in_ready), 32'd1);
    chk("restart_out_valid", 32'(out_valid), 32'd0);
    check_single("restart_clean", encode(8'h5A), 8'h5A, 1'b0, 1'b0);
    check_single("restart_err", encode(8'hC3) ^ 12'h100, 8'hC3, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
